i2c_slave_rx: RTL

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

---
 rtl/i2c_slave_rx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver: address match, register pointer load,
// then one wr_valid pulse per received data byte with auto-incrementing pointer.
module i2c_slave_rx #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_REG_ADDR,
        ST_REG_ACK, ST_DATA, ST_DATA_ACK, ST_IGNORE
    } state_t;

    state_t      state, state_n;
    logic        scl_s1, scl_s2, scl_d;
    logic        sda_s1, sda_s2, sda_d;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  ptr, ptr_n;
    logic        sda_oe_n, wr_valid_n, busy_n;
    logic [7:0]  wr_addr_n, wr_data_n;
    logic [7:0]  byte_in;
    logic        scl_rise, scl_fall, scl_high, start_det, stop_det;

    always_ff @(posedge clk) begin
        if (rst) begin
            {scl_s1, scl_s2, scl_d} <= '1;
            {sda_s1, sda_s2, sda_d} <= '1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    // Both SCL samples high so an SDA edge racing an SCL edge is not a condition.
    assign scl_high  = scl_s2 & scl_d;
    assign start_det = scl_high & sda_d & ~sda_s2;
    assign stop_det  = scl_high & ~sda_d & sda_s2;
    assign byte_in   = {shift[6:0], sda_s2};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            ptr      <= '0;
            sda_oe   <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            ptr      <= ptr_n;
            sda_oe   <= sda_oe_n;
            wr_valid <= wr_valid_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        ptr_n      = ptr;
        sda_oe_n   = sda_oe;
        wr_valid_n = 1'b0;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        busy_n     = busy;
        if (stop_det) begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (start_det) begin
            state_n   = ST_DEV_ADDR;
            bit_cnt_n = '0;
            shift_n   = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ST_DEV_ADDR, ST_REG_ADDR, ST_DATA: begin
                    if (scl_rise) begin
                        shift_n   = byte_in;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            case (state)
                                ST_DEV_ADDR: begin
                                    if (byte_in[7:1] == DEV_ADDR && !byte_in[0]) begin
                                        state_n = ST_DEV_ACK;
                                        busy_n  = 1'b1;
                                    end else begin
                                        state_n = ST_IGNORE;
                                    end
                                end
                                ST_REG_ADDR: begin
                                    ptr_n   = byte_in;
                                    state_n = ST_REG_ACK;
                                end
                                default: begin
                                    wr_valid_n = 1'b1;
                                    wr_addr_n  = ptr;
                                    wr_data_n  = byte_in;
                                    ptr_n      = ptr + 8'd1;
                                    state_n    = ST_DATA_ACK;
                                end
                            endcase
                        end
                    end
                end
                // First SCL fall (end of bit 8) drives ACK, second fall releases and advances.
                ST_DEV_ACK, ST_REG_ACK, ST_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = '0;
                            state_n   = (state == ST_DEV_ACK) ? ST_REG_ADDR : ST_DATA;
                        end
                    end
                end
                default: begin
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

endmodule
